// File: rtl/clk_chk_pkg.sv
// Shared types and constants for the clock-check sequencer.
//   state_e     : sequencer FSM states
//   MIN_WINDOW  : shortest legal window for the default pulse/settle lengths
//   eff_window  : clamps a requested window length to a minimum
package clk_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        PULSE,
        SETTLE,
        WAIT
    } state_e;

    // Pulse (16) + settle (32) + 4 cycles of WAIT margin.
    localparam int unsigned MIN_WINDOW = 52;

    function automatic logic [31:0] eff_window(input logic [31:0] len,
                                               input logic [31:0] min_win);
        return (len < min_win) ? min_win : len;
    endfunction

endpackage

// File: rtl/clk_chk_fail_track.sv
// Per-clock fail bookkeeping: sticky out-of-tolerance flag plus a
// saturating count of failing windows.
//   clk, rst_n : reference clock, async active-low reset
//   i_fail     : 1-cycle strobe, a captured result was out of tolerance
//   i_clr      : 1-cycle clear of flag and counter
//   o_sticky   : set by any fail until cleared
//   o_cnt      : failing-window count, stops at all-ones
module clk_chk_fail_track #(
    parameter int unsigned FAIL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_fail,
    input  logic                  i_clr,
    output logic                  o_sticky,
    output logic [FAIL_CNT_W-1:0] o_cnt
);

    logic                  sticky_q, sticky_d;
    logic [FAIL_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (i_fail) begin
            // A fail in the same cycle as a clear wins: the clear empties the
            // counter and this fail is then its first entry.
            sticky_d = 1'b1;
            if (i_clr) begin
                cnt_d = FAIL_CNT_W'(1);
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_q + FAIL_CNT_W'(1);
            end
        end else if (i_clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_sticky = sticky_q;
    assign o_cnt    = cnt_q;

endmodule

// File: rtl/clock_check_sequencer.sv
// Drives a bank of clock_checker instances from the reference clock domain:
// enables them, issues the periodic latch_count pulse, captures their results
// once settled, and keeps per-clock fail flags and counters.
//   clk, rst_n      : reference clock, async active-low reset
//   i_en            : run enable (rising edge starts a run)
//   i_window_len    : window period in clk cycles (clamped to a minimum)
//   i_clr_sticky    : per-clock clear of sticky flag and fail counter
//   o_chk_en        : checker enable
//   o_latch_count   : checker latch pulse
//   i_clk_in_tol    : per-clock tolerance flags from the checkers
//   i_last_count    : per-clock counts from the checkers
//   o_count         : counts captured in the last completed window
//   o_in_tol        : tolerance flags captured in the last completed window
//   o_valid         : results come from a full window since enable
//   o_update        : 1-cycle strobe when results and fail state update
//   o_sticky_fail   : per-clock sticky out-of-tolerance flags
//   o_fail_cnt      : per-clock saturating fail counters
module clock_check_sequencer
    import clk_chk_pkg::*;
#(
    parameter int unsigned NUM_CLK       = 4,
    parameter int unsigned PULSE_CYCLES  = 16,
    parameter int unsigned SETTLE_CYCLES = 32,
    parameter int unsigned FAIL_CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic [31:0]                   i_window_len,
    input  logic [NUM_CLK-1:0]            i_clr_sticky,
    output logic                          o_chk_en,
    output logic                          o_latch_count,
    input  logic [NUM_CLK-1:0]            i_clk_in_tol,
    input  logic [NUM_CLK*32-1:0]         i_last_count,
    output logic [NUM_CLK*32-1:0]         o_count,
    output logic [NUM_CLK-1:0]            o_in_tol,
    output logic                          o_valid,
    output logic                          o_update,
    output logic [NUM_CLK-1:0]            o_sticky_fail,
    output logic [NUM_CLK*FAIL_CNT_W-1:0] o_fail_cnt
);

    localparam logic [31:0] MIN_WIN    = 32'(PULSE_CYCLES + SETTLE_CYCLES + 4);
    localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] CAPTURE_AT = 32'(PULSE_CYCLES + SETTLE_CYCLES - 1);

    state_e                state_q, state_d;
    logic [31:0]           wcnt_q, wcnt_d;
    logic [31:0]           win_q, win_d;
    logic                  en_q, en_d;
    logic                  armed_q, armed_d;
    logic                  valid_q, valid_d;
    logic                  update_q, update_d;
    logic [NUM_CLK*32-1:0] count_q, count_d;
    logic [NUM_CLK-1:0]    in_tol_q, in_tol_d;
    logic [NUM_CLK-1:0]    fail_evt;
    logic [31:0]           win_next;
    logic                  wrap;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        win_d    = win_q;
        en_d     = i_en;
        armed_d  = armed_q;
        valid_d  = valid_q;
        update_d = 1'b0;
        count_d  = count_q;
        in_tol_d = in_tol_q;
        fail_evt = '0;
        win_next = eff_window(i_window_len, MIN_WIN);
        wrap     = (wcnt_q == win_q - 32'd1);

        if (!i_en) begin
            state_d = IDLE;
            wcnt_d  = '0;
            armed_d = 1'b0;
            valid_d = 1'b0;
        end else if (state_q == IDLE) begin
            // Start only on a rising edge; en_q comes out of reset high so a
            // level held through reset does not launch a run.
            if (!en_q) begin
                state_d = PRIME;
                wcnt_d  = '0;
                win_d   = win_next;
            end
        end else begin
            // Window length is only resampled at the wrap, so mid-window
            // changes land at the next window boundary.
            if (wrap) begin
                wcnt_d = '0;
                win_d  = win_next;
            end else begin
                wcnt_d = wcnt_q + 32'd1;
            end

            case (state_q)
                PRIME, WAIT: begin
                    if (wrap) state_d = PULSE;
                end
                PULSE: begin
                    if (wcnt_q == PULSE_LAST) state_d = SETTLE;
                end
                SETTLE: begin
                    if (wcnt_q == CAPTURE_AT) begin
                        state_d = WAIT;
                        // The first capture is the checker's partial PRIME
                        // count: it only arms the result path.
                        if (armed_q) begin
                            update_d = 1'b1;
                            valid_d  = 1'b1;
                            count_d  = i_last_count;
                            in_tol_d = i_clk_in_tol;
                            fail_evt = ~i_clk_in_tol;
                        end else begin
                            armed_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            win_q    <= '0;
            en_q     <= 1'b1;
            armed_q  <= 1'b0;
            valid_q  <= 1'b0;
            update_q <= 1'b0;
            count_q  <= '0;
            in_tol_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            win_q    <= win_d;
            en_q     <= en_d;
            armed_q  <= armed_d;
            valid_q  <= valid_d;
            update_q <= update_d;
            count_q  <= count_d;
            in_tol_q <= in_tol_d;
        end
    end

    for (genvar k = 0; k < NUM_CLK; k++) begin : g_fail
        clk_chk_fail_track #(
            .FAIL_CNT_W(FAIL_CNT_W)
        ) u_track (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_fail   (fail_evt[k]),
            .i_clr    (i_clr_sticky[k]),
            .o_sticky (o_sticky_fail[k]),
            .o_cnt    (o_fail_cnt[k*FAIL_CNT_W +: FAIL_CNT_W])
        );
    end

    assign o_chk_en      = (state_q != IDLE);
    assign o_latch_count = (state_q == PULSE);
    assign o_count       = count_q;
    assign o_in_tol      = in_tol_q;
    assign o_valid       = valid_q;
    assign o_update      = update_q;

endmodule

// File: tb/tb_clock_check_sequencer.sv
module tb_clock_check_sequencer;

    localparam int unsigned NCLK = 4;
    localparam int unsigned P    = 16;
    localparam int unsigned S    = 32;
    localparam int unsigned FW   = 4;
    localparam int unsigned MINW = P + S + 4;
    localparam int unsigned FMAX = (1 << FW) - 1;

    logic                 clk          = 1'b0;
    logic                 rst_n        = 1'b0;
    logic                 i_en         = 1'b0;
    logic [31:0]          i_window_len = 32'd52;
    logic [NCLK-1:0]      i_clr_sticky = '0;
    logic [NCLK-1:0]      i_clk_in_tol = '1;
    logic [NCLK*32-1:0]   i_last_count = '0;
    logic                 o_chk_en;
    logic                 o_latch_count;
    logic [NCLK*32-1:0]   o_count;
    logic [NCLK-1:0]      o_in_tol;
    logic                 o_valid;
    logic                 o_update;
    logic [NCLK-1:0]      o_sticky_fail;
    logic [NCLK*FW-1:0]   o_fail_cnt;

    int total = 0;
    int bad   = 0;

    clock_check_sequencer #(
        .NUM_CLK       (NCLK),
        .PULSE_CYCLES  (P),
        .SETTLE_CYCLES (S),
        .FAIL_CNT_W    (FW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (i_en),
        .i_window_len  (i_window_len),
        .i_clr_sticky  (i_clr_sticky),
        .o_chk_en      (o_chk_en),
        .o_latch_count (o_latch_count),
        .i_clk_in_tol  (i_clk_in_tol),
        .i_last_count  (i_last_count),
        .o_count       (o_count),
        .o_in_tol      (o_in_tol),
        .o_valid       (o_valid),
        .o_update      (o_update),
        .o_sticky_fail (o_sticky_fail),
        .o_fail_cnt    (o_fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // ---------------- reference model: window index + position ----------------
    bit            m_active  = 1'b0;
    bit            m_prev_en = 1'b1;
    bit            m_valid   = 1'b0;
    bit            m_upd     = 1'b0;
    int unsigned   m_pos     = 0;
    int unsigned   m_idx     = 0;
    int unsigned   m_win     = 0;
    logic [127:0]  m_count   = '0;
    logic [3:0]    m_tol     = '0;
    logic [3:0]    m_sticky  = '0;
    int unsigned   m_cnt[4]  = '{0, 0, 0, 0};

    function automatic int unsigned eff(input logic [31:0] l);
        return (l < MINW) ? MINW : int'(l);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0; m_prev_en = 1; m_valid = 0; m_upd = 0;
            m_pos = 0; m_idx = 0; m_win = 0;
            m_count = '0; m_tol = '0; m_sticky = '0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else begin
            m_upd = 0;
            if (!i_en) begin
                m_active = 0;
                m_valid  = 0;
            end else if (!m_active) begin
                if (!m_prev_en) begin
                    m_active = 1; m_pos = 0; m_idx = 0; m_win = eff(i_window_len);
                end
            end else begin
                // window 0 has no pulse, window 1's result is discarded
                if (m_idx >= 2 && m_pos == P + S - 1) begin
                    m_upd = 1; m_valid = 1; m_count = i_last_count; m_tol = i_clk_in_tol;
                end
                m_pos++;
                if (m_pos == m_win) begin
                    m_pos = 0; m_idx++; m_win = eff(i_window_len);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (m_upd && !i_clk_in_tol[k]) begin
                    m_sticky[k] = 1'b1;
                    m_cnt[k] = i_clr_sticky[k] ? 1 : ((m_cnt[k] < FMAX) ? m_cnt[k] + 1 : FMAX);
                end else if (i_clr_sticky[k]) begin
                    m_sticky[k] = 1'b0;
                    m_cnt[k] = 0;
                end
            end
            m_prev_en = i_en;
        end
    end

    // per-cycle comparison against the model, away from the active edge
    initial begin
        logic [15:0] fc;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) fc[k*4 +: 4] = 4'(m_cnt[k]);
            chk("mon_chk_en", o_chk_en, m_active);
            chk("mon_latch", o_latch_count, m_active && m_idx >= 1 && m_pos < P);
            chk("mon_update", o_update, m_upd);
            chk("mon_valid", o_valid, m_valid);
            chk("mon_count", o_count, m_count);
            chk("mon_in_tol", o_in_tol, m_tol);
            chk("mon_sticky", o_sticky_fail, m_sticky);
            chk("mon_fail_cnt", o_fail_cnt, fc);
        end
    end

    // counts negedges until a rising edge of latch (use_upd=0) or update; -1 on timeout
    task automatic wait_evt(input bit use_upd, input int limit, output int n);
        bit prev;
        bit cur;
        n = 0;
        prev = use_upd ? o_update : o_latch_count;
        forever begin
            @(negedge clk);
            n++;
            cur = use_upd ? o_update : o_latch_count;
            if (cur && !prev) return;
            if (n >= limit) begin
                n = -1;
                return;
            end
            prev = cur;
        end
    endtask

    typedef struct {
        logic [31:0] len;
        int          period;
        logic [31:0] cnt;
        logic [3:0]  tol;
    } vec_t;

    vec_t vt[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int n;

        vt[0] = '{32'd1000,       1000, 32'd1000,     4'hF};
        vt[1] = '{32'd1000,       1000, 32'd900,      4'b1110};
        vt[2] = '{32'd10,         52,   32'hFFFFFFFF, 4'hF};
        vt[3] = '{32'd0,          52,   32'd5,        4'b0101};
        vt[4] = '{32'd52,         52,   32'd52,       4'hF};
        vt[5] = '{32'd53,         53,   32'd53,       4'b1000};
        vt[6] = '{32'd100,        100,  32'd100,      4'hF};

        repeat (3) @(negedge clk);
        chk("rst_chk_en", o_chk_en, 1'b0);
        chk("rst_count", o_count, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        i_en = 1'b1;

        // randomized phase: model-checked every cycle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) i_window_len = $urandom_range(10, 130);
            i_last_count = {$urandom, $urandom, $urandom, $urandom};
            i_clk_in_tol = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            i_clr_sticky = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 499) == 0) i_en = 1'b0;
            else if (!i_en && $urandom_range(0, 3) == 0) i_en = 1'b1;
        end

        // table: period, first-rise delay, update latency, captured values
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            i_en = 1'b0; i_window_len = vt[v].len; i_clr_sticky = '0;
            i_last_count = {4{vt[v].cnt}}; i_clk_in_tol = vt[v].tol;
            @(negedge clk);
            i_en = 1'b1;
            @(negedge clk);
            chk("tbl_chk_en", o_chk_en, 1'b1);
            wait_evt(1'b0, vt[v].period + 5, n);
            chk("tbl_first_rise", n, vt[v].period);
            wait_evt(1'b0, vt[v].period + 5, n);
            chk("tbl_period", n, vt[v].period);
            wait_evt(1'b1, 60, n);
            chk("tbl_upd_latency", n, 48);
            chk("tbl_count", o_count, {4{vt[v].cnt}});
            chk("tbl_in_tol", o_in_tol, vt[v].tol);
            chk("tbl_valid", o_valid, 1'b1);
        end

        // saturation: clock 0 fails every window
        @(negedge clk);
        i_en = 1'b0; i_window_len = 32'd52; i_clr_sticky = 4'hF;
        i_clk_in_tol = 4'b1110; i_last_count = {4{32'd777}};
        @(negedge clk);
        i_clr_sticky = '0; i_en = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 17; k++) begin
            wait_evt(1'b1, 400, n);
            chk("sat_interval", n, (k == 1) ? 152 : 52);
            chk("sat_cnt", o_fail_cnt, 16'((k < 15) ? k : 15));
            chk("sat_sticky", o_sticky_fail, 4'b0001);
        end

        // clear coinciding with a failing capture: set wins
        wait_evt(1'b0, 100, n);
        chk("cc_rise", n, 4);
        repeat (47) @(negedge clk);
        i_clr_sticky = 4'b0011;
        @(negedge clk);
        i_clr_sticky = '0;
        chk("cc_update", o_update, 1'b1);
        chk("cc_sticky", o_sticky_fail, 4'b0001);
        chk("cc_cnt", o_fail_cnt, 16'h0001);

        // disable mid-SETTLE, outputs hold, re-enable restarts through PRIME
        wait_evt(1'b0, 100, n);
        chk("dis_rise", n, 4);
        repeat (20) @(negedge clk);
        i_en = 1'b0;
        repeat (60) @(negedge clk);
        chk("dis_chk_en", o_chk_en, 1'b0);
        chk("dis_valid", o_valid, 1'b0);
        chk("dis_count_hold", o_count, {4{32'd777}});
        chk("dis_cnt_hold", o_fail_cnt, 16'h0001);
        i_en = 1'b1;
        @(negedge clk);
        chk("reen_chk_en", o_chk_en, 1'b1);
        wait_evt(1'b1, 200, n);
        chk("reen_first_update", n, 152);

        // async reset during the pulse
        wait_evt(1'b0, 100, n);
        chk("rst_rise", n, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_latch", o_latch_count, 1'b0);
        chk("arst_chk_en", o_chk_en, 1'b0);
        chk("arst_count", o_count, 128'd0);
        chk("arst_cnt", o_fail_cnt, 16'h0000);
        chk("arst_sticky", o_sticky_fail, 4'h0);
        chk("arst_valid", o_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_idle", o_chk_en, 1'b0);
        i_en = 1'b0;
        @(negedge clk);
        i_en = 1'b1;
        @(negedge clk);
        chk("post_rst_start", o_chk_en, 1'b1);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
